sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 16, the byte-address width; the SRAM word address is ADDRWIDTH-2 bits.
REQ-002 SHALL have port PCLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port PRESETn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have, for each requester n in {0,1}, port REQn, input, 1, access request.
REQ-005 SHALL have ADDRn, input, ADDRWIDTH-2, word address.
REQ-006 SHALL have WENn, input, 4, byte write enables, active high; all-zero means read.
REQ-007 SHALL have WDATAn, input, 32, write data.
REQ-008 SHALL have LOCKn, input, 1, hold ownership for the next cycle.
REQ-009 SHALL have GNTn, output, 1, access accepted this cycle.
REQ-010 SHALL have RVALIDn, output, 1, read data valid.
REQ-011 SHALL have RDATAn, output, 32, read data.
REQ-012 SHALL have SRAM ports SRAMRDATA in 32, SRAMADDR out ADDRWIDTH-2, SRAMWEN out 4, SRAMWDATA out 32, SRAMCS out 1; the SRAM is synchronous with one-cycle read latency.

Function
REQ-013 SHALL grant at most one requester per cycle, combinationally: GNTn=1 only when REQn=1 and requester n wins.
REQ-014 SHALL drive SRAMCS=REQ0|REQ1, and drive SRAMADDR/SRAMWEN/SRAMWDATA from the granted requester; with no grant it SHALL drive SRAMWEN=0, SRAMADDR=0 and SRAMWDATA=0.
REQ-015 SHALL pick the winner as follows:
  - lock holder first;
  - otherwise, when both request, the requester not recorded in the last-grant register LAST (round-robin);
  - otherwise, the sole requester.
REQ-016 SHALL update LAST to the granted index on every grant; LAST holds when there is no grant.
REQ-017 SHALL set the lock owner register when GNTn=1 and LOCKn=1, and clear it on any cycle where the owner does not assert both REQn and LOCKn.
  - While locked, the other requester SHALL get no grant even if requesting.
  - Owner REQn=0 releases the lock in that same cycle.
REQ-018 SHALL use states IDLE (no lock), OWN0, OWN1.
  - IDLE -> OWNn on GNTn&LOCKn.
  - OWNn -> OWNn while REQn&LOCKn.
  - OWNn -> IDLE otherwise, with the arbitration of that cycle being normal round-robin.
REQ-019 SHALL register a read-pending flag and owner index when a granted access has WEN=0.
  - The cycle after, RVALIDn=1 for that owner only, with RDATAn=SRAMRDATA.
  - The other requester's RDATA SHALL be 0.
REQ-020 SHALL drive RVALIDn=0 and RDATAn=0 whenever no read response is pending for n.
REQ-021 SHALL support back-to-back reads with one response per cycle; a new grant in the response cycle is legal.
REQ-022 SHALL complete writes in the grant cycle and produce no RVALID.
REQ-023 SHALL not register request-side inputs: latency is 0 cycles request-to-grant and 1 cycle grant-to-RVALID.

Reset
REQ-024 SHALL, on PRESETn=0 and asynchronously, clear the state to IDLE, LAST to 1 (requester 0 wins the first tie), and the read-pending flag to 0.
REQ-025 SHALL drop a read in flight at reset assertion: no RVALID after reset release.
REQ-026 SHALL hold all outputs at 0 during reset except SRAMCS, which follows REQn.

Structure
REQ-027 SHALL put the state encoding (IDLE/OWN0/OWN1) and the requester-count constant 2 in the shared soc package.
REQ-028 SHALL be a single module; the arbitration decision MAY be a sub-module rr_arb2 (2-way round-robin with lock), and no other sub-modules are used.

Verification
REQ-029 Bench SHALL drive, after reset, REQ0=REQ1=1 for 4 reads -> grants 0,1,0,1, with each RVALID one cycle later to the matching requester only.
REQ-030 Bench SHALL drive REQ0 alone as a write with ADDR0=0x10, WEN0=0xF, WDATA0=0xA5A5A5A5, then a read of 0x10 -> RDATA0=0xA5A5A5A5 with RVALID0 one cycle after GNT0.
REQ-031 Bench SHALL hold REQ0=LOCK0=1 for 3 cycles while REQ1=1 -> GNT0 for 3 cycles, GNT1=0, then GNT1 in the cycle LOCK0 drops.
REQ-032 Bench SHALL write with WEN1=0x3 over existing 0xFFFFFFFF using data 0x00001234 -> readback 0xFFFF1234.
REQ-033 Bench SHALL assert PRESETn low in the cycle after a read grant -> no RVALID after release, state IDLE, requester 0 wins the next tie.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-requester SRAM arbiter.
// No logic of its own; state encoding and requester count live here.
// Imported by sram_arbiter and rr_arb2.
package sram_arbiter_pkg;

  // Number of requesters sharing the SRAM port.
  localparam int NUM_REQ = 2;

  // Lock ownership state: nobody holds the SRAM, or requester 0/1 does.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Index of the granted requester for a one-hot (or zero) grant vector.
  // Only meaningful when the grant vector is non-zero.
  function automatic logic gnt_idx(input logic [NUM_REQ-1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// 2-way round-robin arbiter with lock-holder priority.
// Latency: purely combinational, request to grant in the same cycle.
// Backpressure: a losing requester simply sees no grant and must retry.
import sram_arbiter_pkg::*;

module rr_arb2 (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_hold,
  input  logic               i_last,
  output logic [NUM_REQ-1:0] o_gnt
);

  // Lock holder wins outright; a tie goes to whoever did not win last;
  // otherwise the sole requester (if any) is granted.
  always_comb begin
    o_gnt = '0;
    if (i_hold[0]) begin
      o_gnt = 2'b01;
    end else if (i_hold[1]) begin
      o_gnt = 2'b10;
    end else if (i_req == 2'b11) begin
      o_gnt = i_last ? 2'b01 : 2'b10;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one synchronous single-port SRAM between two requesters, with lock.
// Latency: grant 0 cycles after request, read data 1 cycle after grant.
// Backpressure: requests are not queued; an ungranted requester holds REQ.
import sram_arbiter_pkg::*;

module sram_arbiter #(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  // Requester 0
  input  logic                 REQ0,
  input  logic [ADDRWIDTH-3:0] ADDR0,
  input  logic [3:0]           WEN0,
  input  logic [31:0]          WDATA0,
  input  logic                 LOCK0,
  output logic                 GNT0,
  output logic                 RVALID0,
  output logic [31:0]          RDATA0,
  // Requester 1
  input  logic                 REQ1,
  input  logic [ADDRWIDTH-3:0] ADDR1,
  input  logic [3:0]           WEN1,
  input  logic [31:0]          WDATA1,
  input  logic                 LOCK1,
  output logic                 GNT1,
  output logic                 RVALID1,
  output logic [31:0]          RDATA1,
  // SRAM port
  input  logic [31:0]          SRAMRDATA,
  output logic [ADDRWIDTH-3:0] SRAMADDR,
  output logic [3:0]           SRAMWEN,
  output logic [31:0]          SRAMWDATA,
  output logic                 SRAMCS
);

  localparam int AW = ADDRWIDTH - 2;

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic               r_last;
  logic               r_rd_pend;
  logic               r_rd_idx;

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_hold;
  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_gnt_any;
  logic               w_rd_grant;
  logic               w_rv0;
  logic               w_rv1;

  assign w_req = {REQ1, REQ0};

  // The lock only keeps priority while its owner keeps both REQ and LOCK
  // high; dropping either hands the cycle back to round-robin at once.
  assign w_hold[0] = (r_state == OWN0) && REQ0 && LOCK0;
  assign w_hold[1] = (r_state == OWN1) && REQ1 && LOCK1;

  rr_arb2 u_arb (
    .i_req  (w_req),
    .i_hold (w_hold),
    .i_last (r_last),
    .o_gnt  (w_arb_gnt)
  );

  // Grants are suppressed during reset so every SRAM-side output reads zero.
  assign w_gnt     = w_arb_gnt & {NUM_REQ{PRESETn}};
  assign w_gnt_any = |w_gnt;
  assign GNT0      = w_gnt[0];
  assign GNT1      = w_gnt[1];

  // Chip select follows raw requests, even when nothing is granted.
  assign SRAMCS = REQ0 | REQ1;

  // Steer the granted requester onto the SRAM bus; idle bus is all zeros.
  always_comb begin
    SRAMADDR  = '0;
    SRAMWEN   = '0;
    SRAMWDATA = '0;
    if (w_gnt[0]) begin
      SRAMADDR  = ADDR0;
      SRAMWEN   = WEN0;
      SRAMWDATA = WDATA0;
    end else if (w_gnt[1]) begin
      SRAMADDR  = ADDR1;
      SRAMWEN   = WEN1;
      SRAMWDATA = WDATA1;
    end
  end

  assign w_rd_grant = w_gnt_any && (SRAMWEN == 4'd0);

  // Lock ownership register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a grant with LOCK takes (or keeps) ownership; anything else
  // falls back to IDLE. The owner's own grant is guaranteed while it holds.
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE: begin
        if (w_gnt[0] && LOCK0) begin
          w_state_nxt = OWN0;
        end else if (w_gnt[1] && LOCK1) begin
          w_state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (REQ0 && LOCK0) begin
          w_state_nxt = OWN0;
        end else if (w_gnt[1] && LOCK1) begin
          w_state_nxt = OWN1;
        end
      end
      OWN1: begin
        if (REQ1 && LOCK1) begin
          w_state_nxt = OWN1;
        end else if (w_gnt[0] && LOCK0) begin
          w_state_nxt = OWN0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Remember the last winner for round-robin; reset value favours req 0.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_last <= 1'b1;
    end else if (w_gnt_any) begin
      r_last <= gnt_idx(w_gnt);
    end
  end

  // Track a read issued this cycle so its data is routed back next cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rd_pend <= 1'b0;
      r_rd_idx  <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_grant;
      if (w_rd_grant) begin
        r_rd_idx <= gnt_idx(w_gnt);
      end
    end
  end

  // Only the requester that issued the read sees data; the other reads zero.
  assign w_rv0   = r_rd_pend && !r_rd_idx;
  assign w_rv1   = r_rd_pend &&  r_rd_idx;
  assign RVALID0 = w_rv0;
  assign RVALID1 = w_rv1;
  assign RDATA0  = w_rv0 ? SRAMRDATA : 32'd0;
  assign RDATA1  = w_rv1 ? SRAMRDATA : 32'd0;

endmodule
